// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, fetch FSM state type and opcode helper
package cpu_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_t;

  function automatic logic is_hlt(input logic [3:0] opcode);
    return opcode == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - one-entry fetch buffer: tag, data and valid with hit compare
module fetch_buf import cpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      addr_q  <= wr_addr_i;
      data_q  <= wr_data_i;
    end
  end

  assign hit_o     = valid_q && (addr_q == rd_addr_i);
  assign rd_data_o = data_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch responder: multi-cycle memory reads, refetch buffer, HLT/timeout latching
module fetch_ctrl import cpu_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              fetch_req,
  input  logic              redirect,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              pc_stall,
  output logic              halted,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_en_q, mem_en_d;
  logic [DATA_W-1:0] instruction_q, instruction_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              halted_q, halted_d;
  logic              fetch_err_q, fetch_err_d;

  logic              buf_hit, buf_we;
  logic [DATA_W-1:0] buf_data;
  logic              timed_out;

  fetch_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (buf_we),
    .wr_addr_i (mem_addr_q),
    .wr_data_i (mem_data),
    .rd_addr_i (pc_addr),
    .hit_o     (buf_hit),
    .rd_data_o (buf_data)
  );

  // Counter runs across WAIT and DRAIN; the last allowed cycle is TIMEOUT-1.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_en_q      <= 1'b0;
      instruction_q <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_en_q      <= mem_en_d;
      instruction_q <= instruction_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          if (!buf_hit) state_d = ST_ISSUE;
          else if (is_hlt(buf_data[DATA_W-1 -: 4])) state_d = ST_HALT;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_valid) begin
          if (!redirect && is_hlt(mem_data[DATA_W-1 -: 4])) state_d = ST_HALT;
          else state_d = ST_IDLE;
        end else if (timed_out) begin
          state_d = ST_HALT;
        end else if (redirect) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_valid) state_d = ST_IDLE;
        else if (timed_out) state_d = ST_HALT;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_en_d      = 1'b0;
    instruction_d = instruction_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = 1'b0;
    halted_d      = halted_q;
    fetch_err_d   = fetch_err_q;
    buf_we        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          if (buf_hit) begin
            instruction_d = buf_data;
            instr_pc_d    = pc_addr;
            instr_valid_d = 1'b1;
            halted_d      = is_hlt(buf_data[DATA_W-1 -: 4]);
          end else begin
            mem_addr_d = pc_addr;
            mem_en_d   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (mem_valid) begin
          buf_we = 1'b1;
          if (!redirect) begin
            instruction_d = mem_data;
            instr_pc_d    = mem_addr_q;
            instr_valid_d = 1'b1;
            halted_d      = is_hlt(mem_data[DATA_W-1 -: 4]);
          end
        end else if (timed_out) begin
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mem_valid) begin
          buf_we = 1'b1;
        end else if (timed_out) begin
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pc_stall    = (state_q != ST_IDLE) || (fetch_req && !buf_hit);
  assign mem_addr    = mem_addr_q;
  assign mem_en      = mem_en_q;
  assign instruction = instruction_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with directed fetch scenarios
module tb_fetch_ctrl;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_addr = '0;
  logic        fetch_req = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_data = '0;
  logic        mem_valid = 1'b0;
  logic [15:0] instruction;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        pc_stall;
  logic        halted;
  logic        fetch_err;

  fetch_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .fetch_req   (fetch_req),
    .redirect    (redirect),
    .mem_addr    (mem_addr),
    .mem_en      (mem_en),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .pc_stall    (pc_stall),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
    int          at;
  } instr_exp_t;

  typedef struct {
    logic [15:0] addr;
    int          at;
  } mem_exp_t;

  instr_exp_t exp_instr[$];
  mem_exp_t   exp_mem[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every DUT response must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (instr_valid) begin
        if (exp_instr.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_instr_valid: got pc=%h data=%h want none (cycle %0d)", instr_pc, instruction, cyc);
        end else begin
          instr_exp_t e;
          e = exp_instr.pop_front();
          chk("instruction", {16'h0, instruction}, {16'h0, e.data});
          chk("instr_pc", {16'h0, instr_pc}, {16'h0, e.pc});
          chk("instr_cycle", cyc, e.at);
        end
      end
      if (mem_en) begin
        if (exp_mem.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_mem_en: got addr=%h want none (cycle %0d)", mem_addr, cyc);
        end else begin
          mem_exp_t m;
          m = exp_mem.pop_front();
          chk("mem_addr", {16'h0, mem_addr}, {16'h0, m.addr});
          chk("mem_en_cycle", cyc, m.at);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic req_miss(input logic [15:0] a);
    mem_exp_t m;
    fetch_req = 1'b1;
    pc_addr = a;
    m.addr = a;
    m.at = cyc + 1;
    exp_mem.push_back(m);
    #1 chk("pc_stall_miss", {31'h0, pc_stall}, 32'h1);
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic req_hit(input logic [15:0] a, input logic [15:0] d);
    instr_exp_t e;
    fetch_req = 1'b1;
    pc_addr = a;
    e.data = d;
    e.pc = a;
    e.at = cyc + 1;
    exp_instr.push_back(e);
    #1 chk("pc_stall_hit", {31'h0, pc_stall}, 32'h0);
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic respond(input int c, input logic [15:0] d, input logic [15:0] a, input bit deliver);
    instr_exp_t e;
    wait_until(c);
    mem_valid = 1'b1;
    mem_data = d;
    if (deliver) begin
      e.data = d;
      e.pc = a;
      e.at = c + 1;
      exp_instr.push_back(e);
    end
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic do_reset_and_check();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_instruction", {16'h0, instruction}, 32'h0);
    chk("rst_instr_pc", {16'h0, instr_pc}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_pc_stall", {31'h0, pc_stall}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
  endtask

  initial begin
    int n;
    tick();
    do_reset_and_check();
    tick();

    // Miss with 4-cycle memory, then refetch from the buffer.
    n = cyc;
    req_miss(16'h0010);
    respond(n + 5, 16'hA123, 16'h0010, 1'b1);
    tick();
    req_hit(16'h0010, 16'hA123);
    tick();

    // Redirect one cycle after mem_en: late data is drained silently.
    n = cyc;
    req_miss(16'h0020);
    wait_until(n + 2);
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    respond(n + 5, 16'h1111, 16'h0020, 1'b0);
    n = cyc;
    req_miss(16'h0040);
    respond(n + 3, 16'h2222, 16'h0040, 1'b1);
    tick();

    // Redirect coincident with mem_valid: buffer updated, no delivery.
    n = cyc;
    req_miss(16'h0050);
    wait_until(n + 3);
    redirect = 1'b1;
    mem_valid = 1'b1;
    mem_data = 16'h3333;
    tick();
    redirect = 1'b0;
    mem_valid = 1'b0;
    #1 chk("idle_after_redirect_valid", {31'h0, pc_stall}, 32'h0);
    req_hit(16'h0050, 16'h3333);
    tick();

    // HLT fetched: delivered once, then halted with PC stalled.
    n = cyc;
    req_miss(16'h0060);
    respond(n + 3, 16'hF000, 16'h0060, 1'b1);
    chk("hlt_halted", {31'h0, halted}, 32'h1);
    chk("hlt_fetch_err", {31'h0, fetch_err}, 32'h0);
    fetch_req = 1'b1;
    pc_addr = 16'h0070;
    for (int i = 0; i < 5; i++) begin
      #1 chk("halt_pc_stall", {31'h0, pc_stall}, 32'h1);
      tick();
    end
    fetch_req = 1'b0;
    chk("halt_sticky", {31'h0, halted}, 32'h1);
    do_reset_and_check();
    tick();

    // Fill the buffer with 0x0080, then time out on 0x0090.
    n = cyc;
    req_miss(16'h0080);
    respond(n + 4, 16'h4444, 16'h0080, 1'b1);
    tick();
    n = cyc;
    req_miss(16'h0090);
    wait_until(n + 1 + T);
    chk("timeout_early_err", {31'h0, fetch_err}, 32'h0);
    chk("timeout_early_halt", {31'h0, halted}, 32'h0);
    tick();
    chk("timeout_err", {31'h0, fetch_err}, 32'h1);
    chk("timeout_halt", {31'h0, halted}, 32'h1);
    tick();

    // Reset clears the buffer; stray data afterwards is ignored.
    do_reset_and_check();
    mem_valid = 1'b1;
    mem_data = 16'h5555;
    tick();
    mem_valid = 1'b0;
    tick();
    n = cyc;
    req_miss(16'h0080);
    respond(n + 4, 16'h6666, 16'h0080, 1'b1);

    for (int i = 0; i < 20 && (exp_instr.size() != 0 || exp_mem.size() != 0); i++) tick();
    tick();
    chk("instr_queue_empty", exp_instr.size(), 0);
    chk("mem_queue_empty", exp_mem.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
